// File: rtl/imem_prefetch_buf.sv
// Instruction prefetch buffer: streams word reads from imem into a {pc, instr} FIFO for IF.
// Define IMEM_PF_PERF_EN to add pf_drop_cnt_o, a wrapping count of discarded memory acks.
package imem_pf_pkg;
  typedef struct packed {
    logic        req;
    logic [31:0] addr;
  } type_if2imem_s;

  typedef struct packed {
    logic        ack;
    logic [31:0] r_data;
  } type_imem2if_s;
endpackage

module imem_prefetch_buf
  import imem_pf_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic          clk,
  input  logic          rst,
  output type_if2imem_s if2imem_o,
  input  type_imem2if_s imem2if_i,
  input  logic          redirect_i,
  input  logic [31:0]   redirect_pc_i,
  output logic          instr_valid_o,
  output logic [31:0]   instr_o,
  output logic [31:0]   pc_o,
  input  logic          instr_ready_i
`ifdef IMEM_PF_PERF_EN
  ,
  output logic [31:0]   pf_drop_cnt_o
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);
  localparam logic [CW:0]   OCC_LIMIT  = {1'b0, COUNT_FULL};

  typedef enum logic {RUN, FLUSH} state_e;

  state_e        r_state, w_state_next;
  logic [31:0]   r_issue_pc, w_issue_pc_next;
  logic          r_req_q;
  logic [31:0]   r_addr_q;
  logic [PW-1:0] r_rd_ptr, r_wr_ptr;
  logic [CW-1:0] r_count, w_count_next;
  logic [31:0]   r_pc_mem    [DEPTH];
  logic [31:0]   r_instr_mem [DEPTH];

  logic          w_req, w_push, w_pop, w_lost;
  logic [CW:0]   w_occupancy;
  logic [31:0]   w_redirect_pc;

  // In-flight request reserves a slot, so a returning ack always has room.
  assign w_occupancy   = {1'b0, r_count} + {{CW{1'b0}}, r_req_q};
  assign w_req         = ~rst & (r_state == RUN) & (w_occupancy < OCC_LIMIT);
  assign w_lost        = (r_state == RUN) & r_req_q & ~imem2if_i.ack;
  assign w_push        = (r_state == RUN) & r_req_q & imem2if_i.ack & ~redirect_i;
  assign w_pop         = instr_valid_o & instr_ready_i & ~redirect_i;
  assign w_redirect_pc = redirect_pc_i & 32'hFFFF_FFFC;

  always_comb begin
    w_state_next    = r_state;
    w_issue_pc_next = r_issue_pc;
    w_count_next    = r_count;
    if (redirect_i) begin
      w_state_next    = FLUSH;
      w_issue_pc_next = w_redirect_pc;
      w_count_next    = '0;
    end else begin
      if (w_lost) begin
        // Buffered entries precede addr_q, so only the fetch stream restarts.
        w_state_next    = FLUSH;
        w_issue_pc_next = r_addr_q;
      end else begin
        w_state_next = RUN;
        if (w_req) begin
          w_issue_pc_next = r_issue_pc + 32'd4;
        end
      end
      w_count_next = r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= RUN;
      r_issue_pc <= RESET_PC;
      r_req_q    <= 1'b0;
      r_addr_q   <= '0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
    end else begin
      r_state    <= w_state_next;
      r_issue_pc <= w_issue_pc_next;
      r_count    <= w_count_next;
      r_req_q    <= w_req;
      if (w_req) begin
        r_addr_q <= r_issue_pc;
      end
      if (redirect_i) begin
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pc_mem[r_wr_ptr]    <= r_addr_q;
      r_instr_mem[r_wr_ptr] <= imem2if_i.r_data;
    end
  end

  assign if2imem_o.req  = w_req;
  assign if2imem_o.addr = r_issue_pc;
  assign instr_valid_o  = (r_count != '0);
  assign instr_o        = r_instr_mem[r_rd_ptr];
  assign pc_o           = r_pc_mem[r_rd_ptr];

  a_no_push_when_full: assert property (@(posedge clk) disable iff (rst)
    !(w_push && (r_count == COUNT_FULL)));

`ifdef IMEM_PF_PERF_EN
  logic        w_drop;
  logic [31:0] r_drop_cnt;

  assign w_drop = imem2if_i.ack & ((r_state == FLUSH) | (redirect_i & r_req_q));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_drop_cnt <= '0;
    end else if (w_drop) begin
      r_drop_cnt <= r_drop_cnt + 32'd1;
    end
  end

  assign pf_drop_cnt_o = r_drop_cnt;
`endif

endmodule

// File: tb/tb_imem_prefetch_buf.sv
// Scoreboard bench for imem_prefetch_buf: a memory model answers requests, a monitor checks
// every consumed {pc, instr} against the expected fetch stream queued by the directed phases.
`timescale 1ns/1ps
module tb_imem_prefetch_buf;
  import imem_pf_pkg::*;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  type_if2imem_s if2imem;
  type_imem2if_s imem2if;
  logic          redirect = 1'b0;
  logic [31:0]   redirect_pc = 32'h0;
  logic          valid;
  logic [31:0]   instr, pc;
  logic          ready = 1'b0;
`ifdef IMEM_PF_PERF_EN
  logic [31:0]   drop_cnt;
`endif

  int          checks = 0;
  int          failures = 0;
  int          cycle = 0;
  logic [31:0] exp_q[$];
  logic [31:0] req_addr_log[$];
  int          req_cycle_log[$];
  logic        withhold_armed = 1'b0;
  logic [31:0] withhold_addr = 32'h0;

  imem_prefetch_buf #(.DEPTH(4), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .if2imem_o(if2imem), .imem2if_i(imem2if),
    .redirect_i(redirect), .redirect_pc_i(redirect_pc),
    .instr_valid_o(valid), .instr_o(instr), .pc_o(pc), .instr_ready_i(ready)
`ifdef IMEM_PF_PERF_EN
    , .pf_drop_cnt_o(drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_from(input logic [31:0] base, input int n);
    exp_q.delete();
    for (int k = 0; k < n; k++) exp_q.push_back(base + 32'(4 * k));
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cycle++;
    end
  end

  // Memory samples the request at negedge and answers during the next cycle.
  initial begin
    logic        s_req;
    logic [31:0] s_addr;
    imem2if = '0;
    forever begin
      @(negedge clk);
      s_req  = if2imem.req;
      s_addr = if2imem.addr;
      if (s_req) begin
        req_addr_log.push_back(s_addr);
        req_cycle_log.push_back(cycle);
      end
      @(posedge clk);
      #1;
      imem2if.ack    = s_req && !(withhold_armed && s_addr == withhold_addr);
      imem2if.r_data = s_req ? instr_of(s_addr) : 32'h0;
      if (s_req && withhold_armed && s_addr == withhold_addr) withhold_armed = 1'b0;
    end
  end

  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (!rst && valid && ready && !redirect) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL pop_unexpected: got pc %h, expected no entry", pc);
        end else begin
          e = exp_q.pop_front();
          check("pop_pc", pc, e);
          check("pop_instr", instr, instr_of(e));
        end
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, n1, idx, logstart;
`ifdef IMEM_PF_PERF_EN
    logic [31:0] d0;
`endif
    // Reset and first fetches.
    rst = 1'b1; ready = 1'b1;
    expect_from(RESET_PC, 64);
    cyc(3);
    @(negedge clk);
    check("reset_req", 32'(if2imem.req), 32'd0);
    check("reset_valid", 32'(valid), 32'd0);
`ifdef IMEM_PF_PERF_EN
    check("reset_drop_cnt", drop_cnt, 32'd0);
`endif
    cyc(1); rst = 1'b0;
    @(negedge clk);
    check("c0_req", 32'(if2imem.req), 32'd1);
    check("c0_addr", if2imem.addr, RESET_PC);
    cyc(1);
    @(negedge clk);
    check("c1_addr", if2imem.addr, RESET_PC + 32'd4);
    check("c1_valid", 32'(valid), 32'd0);
    cyc(1);
    @(negedge clk);
    check("c2_valid", 32'(valid), 32'd1);
    check("c2_pc", pc, RESET_PC);
    cyc(8);

    // Backpressure: fill, then a single pop frees exactly one request.
    ready = 1'b0;
    cyc(6);
    n0 = req_addr_log.size();
    cyc(4);
    n1 = req_addr_log.size();
    check("stall_no_req", 32'(n1 - n0), 32'd0);
    @(negedge clk);
    check("stall_valid", 32'(valid), 32'd1);
    check("stall_req", 32'(if2imem.req), 32'd0);
    cyc(1);
    ready = 1'b1;
    n0 = req_addr_log.size();
    cyc(1); ready = 1'b0;
    cyc(5);
    n1 = req_addr_log.size();
    check("one_pop_one_req", 32'(n1 - n0), 32'd1);

    // Redirect with three entries buffered and a request going out.
    ready = 1'b1;
    cyc(1);
    ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h8000_0102;
    expect_from(32'h8000_0100, 64);
`ifdef IMEM_PF_PERF_EN
    d0 = drop_cnt;
`endif
    @(negedge clk);
    check("r0_valid", 32'(valid), 32'd1);
    cyc(1); redirect = 1'b0; ready = 1'b1;
    @(negedge clk);
    check("r1_valid", 32'(valid), 32'd0);
    check("r1_req", 32'(if2imem.req), 32'd0);
    cyc(1);
    @(negedge clk);
    check("r2_req", 32'(if2imem.req), 32'd1);
    check("r2_addr", if2imem.addr, 32'h8000_0100);
    cyc(1);
    @(negedge clk);
    check("r3_valid", 32'(valid), 32'd0);
    cyc(1);
    @(negedge clk);
    check("r4_valid", 32'(valid), 32'd1);
    check("r4_pc", pc, 32'h8000_0100);
`ifdef IMEM_PF_PERF_EN
    check("r_drop_delta", drop_cnt - d0, 32'd1);
`endif
    cyc(8);

    // Redirect colliding with a push and a pop.
    redirect = 1'b1; redirect_pc = 32'h8000_0200;
    expect_from(32'h8000_0200, 64);
`ifdef IMEM_PF_PERF_EN
    d0 = drop_cnt;
`endif
    @(negedge clk);
    check("s0_valid", 32'(valid), 32'd1);
    cyc(1); redirect = 1'b0;
    @(negedge clk);
    check("s1_valid", 32'(valid), 32'd0);
    cyc(1);
`ifdef IMEM_PF_PERF_EN
    check("s_drop_delta", drop_cnt - d0, 32'd2);
`endif
    cyc(2);
    @(negedge clk);
    check("s4_pc", pc, 32'h8000_0200);
    cyc(6);

    // Lost response at RESET_PC+0x10.
    redirect = 1'b1; redirect_pc = RESET_PC;
    expect_from(RESET_PC, 64);
    withhold_addr = RESET_PC + 32'h10; withhold_armed = 1'b1;
    logstart = req_addr_log.size();
    cyc(1); redirect = 1'b0;
    cyc(3);
`ifdef IMEM_PF_PERF_EN
    d0 = drop_cnt;
`endif
    cyc(17);
    idx = -1;
    for (int k = logstart; k < req_addr_log.size(); k++)
      if (idx < 0 && req_addr_log[k] == RESET_PC + 32'h10) idx = k;
    if (idx < 0 || idx + 3 >= req_addr_log.size()) begin
      checks++;
      failures++;
      $display("FAIL lost_seq: got no request sequence at %h, expected one", RESET_PC + 32'h10);
    end else begin
      check("lost_next", req_addr_log[idx + 1], RESET_PC + 32'h14);
      check("lost_reissue", req_addr_log[idx + 2], RESET_PC + 32'h10);
      check("lost_gap", 32'(req_cycle_log[idx + 2] - req_cycle_log[idx]), 32'd3);
      check("lost_after", req_addr_log[idx + 3], RESET_PC + 32'h14);
    end
`ifdef IMEM_PF_PERF_EN
    check("lost_drop_delta", drop_cnt - d0, 32'd1);
`endif

    // Reset mid-stream with a request in flight.
    rst = 1'b1;
    expect_from(RESET_PC, 64);
    cyc(1);
    @(negedge clk);
    check("t1_req", 32'(if2imem.req), 32'd0);
    check("t1_valid", 32'(valid), 32'd0);
`ifdef IMEM_PF_PERF_EN
    check("t1_drop_cnt", drop_cnt, 32'd0);
`endif
    cyc(1); rst = 1'b0;
    @(negedge clk);
    check("t2_req", 32'(if2imem.req), 32'd1);
    check("t2_addr", if2imem.addr, RESET_PC);
    cyc(2);
    @(negedge clk);
    check("t4_valid", 32'(valid), 32'd1);
    check("t4_pc", pc, RESET_PC);
    cyc(6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
